// File: rtl/alu_seq_pkg.sv
// Shared opcodes, iterative-engine op codes, FSM state encoding and
// group-decode helpers for the handshaked sequential ALU.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b0_0000;
  localparam logic [4:0] OP_SUB  = 5'b0_0001;
  localparam logic [4:0] OP_INC  = 5'b0_0010;
  localparam logic [4:0] OP_DEC  = 5'b0_0011;
  localparam logic [4:0] OP_AND  = 5'b0_1000;
  localparam logic [4:0] OP_OR   = 5'b0_1001;
  localparam logic [4:0] OP_XOR  = 5'b0_1010;
  localparam logic [4:0] OP_NOT  = 5'b0_1011;
  localparam logic [4:0] OP_SHL1 = 5'b0_1100;
  localparam logic [4:0] OP_SHR1 = 5'b0_1101;
  localparam logic [4:0] OP_ROL1 = 5'b0_1110;
  localparam logic [4:0] OP_ROR1 = 5'b0_1111;
  localparam logic [4:0] OP_MUL  = 5'b1_0000;
  localparam logic [4:0] OP_SHLN = 5'b1_0001;
  localparam logic [4:0] OP_SHRN = 5'b1_0010;

  // Engine op codes line up with the low two bits of the multi-cycle opcodes.
  localparam logic [1:0] ITER_MUL = 2'b00;
  localparam logic [1:0] ITER_SHL = 2'b01;
  localparam logic [1:0] ITER_SHR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [4:0] sel);
    return sel[4:2] == 3'b000;
  endfunction

  function automatic logic is_mul(input logic [4:0] sel);
    return sel == OP_MUL;
  endfunction

  function automatic logic is_shift_n(input logic [4:0] sel);
    return (sel == OP_SHLN) || (sel == OP_SHRN);
  endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative engine: shift-add multiplier and one-bit-per-cycle barrel
// replacement. The first step runs on the start edge itself.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic                     done,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic                     carry
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [SHW:0] MUL_ITERS = (SHW + 1)'(WIDTH);
  localparam logic [SHW:0] CNT_ONE   = (SHW + 1)'(1);

  logic [WIDTH-1:0] hi_reg, lo_reg, mcand_reg;
  logic [1:0]       op_reg;
  logic [SHW:0]     count_reg;
  logic             carry_reg, done_reg;

  logic [1:0]       src_op;
  logic [WIDTH-1:0] src_hi, src_lo, src_mcand;
  logic [SHW:0]     src_count;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             step_carry, active;

  // On start the step operates on the freshly presented operands, so a
  // job of N steps finishes N-1 edges after start.
  always_comb begin
    src_op    = start ? op : op_reg;
    src_hi    = start ? '0 : hi_reg;
    src_lo    = start ? ((op == ITER_MUL) ? B : A) : lo_reg;
    src_mcand = start ? A : mcand_reg;
    src_count = start ? ((op == ITER_MUL) ? MUL_ITERS : {1'b0, amount}) : count_reg;
    active    = start || (count_reg != '0);
    acc_sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_mcand} : '0);
    step_hi    = src_hi;
    step_lo    = src_lo;
    step_carry = 1'b0;
    case (src_op)
      ITER_MUL: begin
        step_hi = acc_sum[WIDTH:1];
        step_lo = {acc_sum[0], src_lo[MSB:1]};
      end
      ITER_SHL: begin
        step_lo    = {src_lo[MSB-1:0], 1'b0};
        step_carry = src_lo[MSB];
      end
      ITER_SHR: begin
        step_lo    = {1'b0, src_lo[MSB:1]};
        step_carry = src_lo[0];
      end
      default: begin
        step_lo = src_lo;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      lo_reg    <= '0;
      mcand_reg <= '0;
      op_reg    <= ITER_MUL;
      count_reg <= '0;
      carry_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (active) begin
        hi_reg    <= step_hi;
        lo_reg    <= step_lo;
        carry_reg <= step_carry;
        count_reg <= src_count - CNT_ONE;
        done_reg  <= (src_count == CNT_ONE);
        if (start) begin
          op_reg    <= op;
          mcand_reg <= A;
        end
      end
    end
  end

  assign done  = done_reg;
  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign carry = (op_reg == ITER_MUL) ? (hi_reg != '0) : carry_reg;

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle datapath, IDLE/BUSY/DONE control and the
// registered result/flag bank; multi-cycle work is handed to alu_seq_iter.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_Out,
  output logic [WIDTH-1:0] ALU_Out_Hi,
  output logic             CarryOut,
  output logic             overflow,
  output logic             zero,
  output logic             equal,
  output logic             greater,
  output logic             smaller,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_reg;
  logic [WIDTH-1:0] out_reg, hi_reg;
  logic             valid_reg, carry_reg, ovf_reg, zero_reg;
  logic             eq_reg, gt_reg, lt_reg, ill_reg;
  logic [2:0]       cmp_pend_reg;

  logic             accept, go_busy;
  logic [SHW-1:0]   amount;
  logic [WIDTH-1:0] b_op, sc_out, rol1, ror1;
  logic [WIDTH:0]   arith;
  logic             sc_carry, sc_ovf, sc_ill;
  logic [2:0]       cmp;
  logic             iter_done, iter_carry;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign amount   = B[SHW-1:0];
  assign in_ready = rst_n && ((state_reg == IDLE) || ((state_reg == DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign go_busy  = (is_mul(ALU_Sel) && MUL_EN) || (is_shift_n(ALU_Sel) && (amount != '0));
  assign cmp      = {A == B, A > B, A < B};

  genvar gi;
  for (gi = 0; gi < WIDTH; gi++) begin : g_rot
    assign rol1[gi] = A[(gi + WIDTH - 1) % WIDTH];
    assign ror1[gi] = A[(gi + 1) % WIDTH];
  end

  // INC/DEC reuse the ADD/SUB adder with a constant 1 as second operand.
  always_comb begin
    b_op     = ALU_Sel[1] ? ONE : B;
    arith    = ALU_Sel[0] ? ({1'b0, A} - {1'b0, b_op}) : ({1'b0, A} + {1'b0, b_op});
    sc_out   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    sc_ill   = 1'b0;
    if (is_arith(ALU_Sel)) begin
      sc_out   = arith[MSB:0];
      sc_carry = arith[WIDTH];
      sc_ovf   = ALU_Sel[0] ? ((A[MSB] != b_op[MSB]) && (arith[MSB] != A[MSB]))
                            : ((A[MSB] == b_op[MSB]) && (arith[MSB] != A[MSB]));
    end else begin
      case (ALU_Sel)
        OP_AND:  sc_out = A & B;
        OP_OR:   sc_out = A | B;
        OP_XOR:  sc_out = A ^ B;
        OP_NOT:  sc_out = ~A;
        OP_SHL1: begin
          sc_out   = {A[MSB-1:0], 1'b0};
          sc_carry = A[MSB];
        end
        OP_SHR1: begin
          sc_out   = {1'b0, A[MSB:1]};
          sc_carry = A[0];
        end
        OP_ROL1: sc_out = rol1;
        OP_ROR1: sc_out = ror1;
        OP_MUL:  sc_ill = !MUL_EN;
        OP_SHLN, OP_SHRN: sc_out = A;  // only reached here for amount 0
        default: sc_ill = 1'b1;
      endcase
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && go_busy),
    .op     (ALU_Sel[1:0]),
    .A      (A),
    .B      (B),
    .amount (amount),
    .done   (iter_done),
    .hi     (iter_hi),
    .lo     (iter_lo),
    .carry  (iter_carry)
  );

  // Result bank only changes on entry to DONE, so BUSY shows the old result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      valid_reg    <= 1'b0;
      out_reg      <= '0;
      hi_reg       <= '0;
      carry_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      zero_reg     <= 1'b0;
      eq_reg       <= 1'b0;
      gt_reg       <= 1'b0;
      lt_reg       <= 1'b0;
      ill_reg      <= 1'b0;
      cmp_pend_reg <= '0;
    end else begin
      case (state_reg)
        BUSY: begin
          if (iter_done) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
            out_reg   <= iter_lo;
            hi_reg    <= iter_hi;
            carry_reg <= iter_carry;
            ovf_reg   <= 1'b0;
            zero_reg  <= (iter_lo == '0);
            {eq_reg, gt_reg, lt_reg} <= cmp_pend_reg;
            ill_reg   <= 1'b0;
          end
        end
        default: begin
          if (accept) begin
            if (go_busy) begin
              state_reg    <= BUSY;
              valid_reg    <= 1'b0;
              cmp_pend_reg <= cmp;
            end else begin
              state_reg <= DONE;
              valid_reg <= 1'b1;
              out_reg   <= sc_out;
              hi_reg    <= '0;
              carry_reg <= sc_carry;
              ovf_reg   <= sc_ovf;
              zero_reg  <= !sc_ill && (sc_out == '0);
              {eq_reg, gt_reg, lt_reg} <= cmp;
              ill_reg   <= sc_ill;
            end
          end else if ((state_reg == DONE) && out_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign out_valid  = valid_reg;
  assign ALU_Out    = out_reg;
  assign ALU_Out_Hi = hi_reg;
  assign CarryOut   = carry_reg;
  assign overflow   = ovf_reg;
  assign zero       = zero_reg;
  assign equal      = eq_reg;
  assign greater    = gt_reg;
  assign smaller    = lt_reg;
  assign illegal    = ill_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=8: directed vectors push expected
// results; a monitor pops and compares whenever a result is consumed.
module tb_alu_seq;

  localparam logic [4:0] T_ADD = 5'h00, T_SUB = 5'h01, T_INC = 5'h02, T_DEC = 5'h03;
  localparam logic [4:0] T_AND = 5'h08, T_OR = 5'h09, T_XOR = 5'h0A, T_NOT = 5'h0B;
  localparam logic [4:0] T_SHL1 = 5'h0C, T_SHR1 = 5'h0D, T_ROL1 = 5'h0E, T_ROR1 = 5'h0F;
  localparam logic [4:0] T_MUL = 5'h10, T_SHLN = 5'h11, T_SHRN = 5'h12;

  // flags order: {carry, overflow, zero, equal, greater, smaller, illegal}
  typedef struct {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] out;
    logic [7:0] hi;
    logic [6:0] flags;
    bit         chk_zero;
    int         lat;
    int         acc_cyc;
  } exp_t;

  logic       clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [7:0] A, B, ALU_Out, ALU_Out_Hi;
  logic [4:0] ALU_Sel;
  logic       CarryOut, overflow, zero, equal, greater, smaller, illegal;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   lat_seen = 0;
  exp_t sb_q[$];
  exp_t vec[$];

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALU_Sel(ALU_Sel), .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Out(ALU_Out), .ALU_Out_Hi(ALU_Out_Hi), .CarryOut(CarryOut), .overflow(overflow),
    .zero(zero), .equal(equal), .greater(greater), .smaller(smaller), .illegal(illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] out, input logic [7:0] hi,
                              input logic [6:0] flags, input int lat, input bit chk_zero);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.out = out; e.hi = hi; e.flags = flags;
    e.lat = lat; e.chk_zero = chk_zero; e.acc_cyc = 0;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h cyc=%0d", name, got, want, cyc);
    end
  endtask

  // Caller is at a negedge: drive, wait (bounded) for in_ready, record the accept.
  task automatic issue_now(input exp_t e, input bit push, output int waited);
    waited = 0;
    in_valid = 1'b1; A = e.a; B = e.b; ALU_Sel = e.op;
    #1;
    while (!in_ready && waited < 40) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout op=%b got=not_accepted want=accepted", e.op);
      in_valid = 1'b0;
      return;
    end
    e.acc_cyc = cyc;
    if (push) sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue(input exp_t e, input bit push);
    int w;
    @(negedge clk);
    issue_now(e, push, w);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout got=%0d pending want=0", sb_q.size());
    end
  endtask

  // Monitor: latency on first sight of a result, full compare on consumption.
  initial begin
    exp_t e;
    logic [22:0] got, want;
    int lat;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        lat_seen = 0;
      end else if (out_valid) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid got=out_valid=1 want=0 cyc=%0d", cyc);
        end else begin
          e = sb_q[0];
          if (!lat_seen) begin
            lat = cyc - e.acc_cyc;
            lat_seen = 1;
            checks++;
            if (lat != e.lat) begin
              failures++;
              $display("FAIL latency op=%b A=%h B=%h got=%0d want=%0d", e.op, e.a, e.b, lat, e.lat);
            end
          end
          if (out_ready) begin
            got  = {ALU_Out, ALU_Out_Hi, CarryOut, overflow, (e.chk_zero ? zero : e.flags[4]),
                    equal, greater, smaller, illegal};
            want = {e.out, e.hi, e.flags};
            checks++;
            if (got !== want) begin
              failures++;
              $display("FAIL result op=%b A=%h B=%h got=%h want=%h", e.op, e.a, e.b, got, want);
            end else begin
              $display("txn op=%b A=%h B=%h out=%h hi=%h flags=%b lat=%0d",
                       e.op, e.a, e.b, ALU_Out, ALU_Out_Hi, e.flags, lat);
            end
            void'(sb_q.pop_front());
            lat_seen = 0;
          end
        end
      end
    end
  end

  initial begin
    int w;
    bit seen_valid;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; ALU_Sel = '0;

    vec.push_back(mk(T_ADD,  8'hF0, 8'h20, 8'h10, 8'h00, 7'b1000100, 1, 1));
    vec.push_back(mk(T_SUB,  8'h80, 8'h01, 8'h7F, 8'h00, 7'b0100100, 1, 1));
    vec.push_back(mk(T_SUB,  8'h00, 8'h01, 8'hFF, 8'h00, 7'b1000010, 1, 1));
    vec.push_back(mk(T_ADD,  8'h7F, 8'h01, 8'h80, 8'h00, 7'b0100100, 1, 1));
    vec.push_back(mk(T_INC,  8'hFF, 8'h00, 8'h00, 8'h00, 7'b1010100, 1, 1));
    vec.push_back(mk(T_DEC,  8'h00, 8'h00, 8'hFF, 8'h00, 7'b1001000, 1, 1));
    vec.push_back(mk(T_DEC,  8'h80, 8'h00, 8'h7F, 8'h00, 7'b0100100, 1, 1));
    vec.push_back(mk(T_AND,  8'hF0, 8'h3C, 8'h30, 8'h00, 7'b0000100, 1, 1));
    vec.push_back(mk(T_OR,   8'hF0, 8'h3C, 8'hFC, 8'h00, 7'b0000100, 1, 1));
    vec.push_back(mk(T_XOR,  8'h3C, 8'h3C, 8'h00, 8'h00, 7'b0011000, 1, 1));
    vec.push_back(mk(T_NOT,  8'h0F, 8'hF0, 8'hF0, 8'h00, 7'b0000010, 1, 1));
    vec.push_back(mk(T_SHL1, 8'h81, 8'h00, 8'h02, 8'h00, 7'b1000100, 1, 1));
    vec.push_back(mk(T_SHR1, 8'h81, 8'h00, 8'h40, 8'h00, 7'b1000100, 1, 1));
    vec.push_back(mk(T_ROL1, 8'h81, 8'h00, 8'h03, 8'h00, 7'b0000100, 1, 1));
    vec.push_back(mk(T_ROR1, 8'h81, 8'h00, 8'hC0, 8'h00, 7'b0000100, 1, 1));
    vec.push_back(mk(T_MUL,  8'h0D, 8'h0B, 8'h8F, 8'h00, 7'b0000100, 9, 1));
    vec.push_back(mk(T_SHLN, 8'h81, 8'h03, 8'h08, 8'h00, 7'b0000100, 4, 1));
    vec.push_back(mk(T_SHRN, 8'h81, 8'h00, 8'h81, 8'h00, 7'b0000100, 1, 1));
    vec.push_back(mk(T_SHLN, 8'hF0, 8'h04, 8'h00, 8'h00, 7'b1010100, 5, 1));
    vec.push_back(mk(T_SHRN, 8'h81, 8'h07, 8'h01, 8'h00, 7'b0000100, 8, 1));
    vec.push_back(mk(5'h04,  8'h03, 8'h03, 8'h00, 8'h00, 7'b0001001, 1, 0));
    vec.push_back(mk(5'h13,  8'h09, 8'h02, 8'h00, 8'h00, 7'b0000101, 1, 0));

    @(negedge clk); #1;
    check("reset_outputs_zero", 32'({out_valid, in_ready, ALU_Out, ALU_Out_Hi, CarryOut, overflow,
                                      zero, equal, greater, smaller, illegal}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vec[i]) issue(vec[i], 1'b1);
    wait_drain();

    // MUL: busy for the whole iteration run, result after WIDTH+1 cycles.
    issue(mk(T_MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 7'b1001000, 9, 1), 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      check($sformatf("mul_busy_ready_valid_c%0d", i), 32'({in_ready, out_valid}), 32'd0);
    end
    wait_drain();

    // Backpressure: result held stable, input side blocked.
    @(negedge clk);
    out_ready = 1'b0;
    issue(mk(T_ADD, 8'hF0, 8'h20, 8'h10, 8'h00, 7'b1000100, 1, 1), 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check($sformatf("bp_hold_c%0d", i), 32'({out_valid, in_ready, ALU_Out, CarryOut, greater}),
            32'({1'b1, 1'b0, 8'h10, 1'b1, 1'b1}));
    end
    @(negedge clk);
    out_ready = 1'b1;
    issue_now(mk(T_XOR, 8'hAA, 8'h55, 8'hFF, 8'h00, 7'b0000100, 1, 1), 1'b1, w);
    check("bp_accept_same_edge_waits", 32'(w), 32'd0);
    wait_drain();

    // Reset in the middle of a MUL: everything clears, no result ever appears.
    issue(mk(T_MUL, 8'h12, 8'h34, 8'h00, 8'h00, 7'b0, 9, 1), 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midmul_reset_outputs_zero", 32'({out_valid, in_ready, ALU_Out, ALU_Out_Hi, CarryOut, overflow,
                                             zero, equal, greater, smaller, illegal}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk); #1;
      if (out_valid) seen_valid = 1;
    end
    check("midmul_no_valid_after_reset", 32'(seen_valid), 32'd0);
    issue(mk(5'h1F, 8'h05, 8'h09, 8'h00, 8'h00, 7'b0000011, 1, 0), 1'b1);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
